pc_gen: RTL and testbench
=========================

# pc_gen

Parametrised program-counter generator: the next generation of the fetch-stage PC register. It generalises address width, reset vector, step size and the number of redirect sources. Unlike its predecessor, it adds a fetch-ready handshake, a pending-redirect latch so redirects arriving during a stall are never lost, target alignment checking, and a halt mode. It sits at the head of the IF stage, driving the instruction-memory address and chip-enable.

## Interface
- ADDR_W, 32: PC / target width.
- RESET_VEC, 0: PC value loaded on reset.
- STEP, 4: sequential increment, added modulo 2^ADDR_W.
- ALIGN_BITS, 2: number of low target bits that must be zero.
- NUM_REDIR, 2: redirect sources; index 0 has the highest priority.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- stall_i  in  1  pipeline stall from ctrl (stall[0]).
- fetch_ready_i  in  1  instruction memory accepts pc_o this cycle.
- halt_i  in  1  request to stop fetching.
- redir_valid_i  in  NUM_REDIR  redirect request per source.
- redir_target_i  in  NUM_REDIR*ADDR_W  targets; source k occupies bits [k*ADDR_W +: ADDR_W].
- pc_o  out  ADDR_W  current fetch address.
- ce_o  out  1  pc_o valid / instruction-memory chip enable.
- misalign_o  out  1  one-cycle pulse: an applied or latched target was misaligned.
- redir_pending_o  out  1  a latched redirect is waiting.

## Operation
- States: RST_S, RUN, HALT.
  - RST_S: ce_o=0; redirects ignored.
  - RUN: ce_o=1.
  - HALT: ce_o=0; pc_o held.
- Reset values: state RST_S, pc_o=RESET_VEC, ce_o=0, misalign_o=0, redir_pending_o=0, pending target 0.
- RST_S → RUN on the first edge with rst=0. pc_o stays RESET_VEC, so the first valid fetch is RESET_VEC.
- fire = RUN & ce_o & fetch_ready_i & !stall_i.
- Winning redirect = lowest index k with redir_valid_i[k]=1. Its target is aligned by forcing the low ALIGN_BITS to 0. If any of those bits were nonzero, misalign_o=1 next cycle.
- Next-PC priority when fire is high:
  1. Winning redirect this cycle.
  2. Otherwise the pending target.
  3. Otherwise pc_o+STEP.
  The pending latch clears on any fire.
- When a redirect arrives in RUN without fire, the aligned winning target is written into the pending register and redir_pending_o is set. A later redirect overwrites it, since the newest redirect is always the youngest correct path. pc_o is held.
- halt_i=1 in RUN → HALT next cycle, regardless of fire. If fire and halt_i coincide, the PC update still occurs.
- In HALT:
  - A redirect → RUN with pc_o = aligned target. This wins over halt_i, and pending clears.
  - Otherwise, halt_i=0 → RUN. pc_o is unchanged, pending is preserved and is consumed at the next fire.
- rst overrides everything, including mid-stall and in HALT; pending is discarded.
- Wrap-around: pc_o+STEP past 2^ADDR_W-1 wraps modulo 2^ADDR_W, with no flag.

## Timing
- Redirect-to-pc_o latency: 1 cycle when fire is high in the same cycle. Otherwise it takes effect on the first fire cycle.
- misalign_o is registered and asserted for exactly one cycle per offending accepted redirect, whether applied or latched.
- ce_o rises exactly 1 cycle after rst falls.
- No combinational path from any input to pc_o, ce_o or redir_pending_o; all outputs are registered.
- stall_i=1 and fetch_ready_i=0 are equivalent for advancement; both hold pc_o.

## Test plan
- Reset release, RESET_VEC=0x100, ready=1 → ce_o=0 for the rst cycle, then pc_o sequence 0x100, 0x100, 0x104, 0x108 (first edge only raises ce_o).
- Redirects: valid=2'b11, target0=0x200, target1=0x300, fire=1 → next pc_o=0x200; then 0x204.
- Pending: stall_i=1 for 3 cycles; redirect source 1 to 0x400 in stall cycle 1 → redir_pending_o=1, pc_o held; after stall drops, pc_o=0x400 and pending=0. Repeat with a second redirect to 0x500 during the stall → 0x500 wins.
- Misalignment: target 0x1003, ALIGN_BITS=2, fire=1 → pc_o=0x1000; misalign_o high for exactly one cycle.
- Halt: halt_i pulsed at pc 0x20 → ce_o=0, pc held. Release halt → resumes with ce_o=1 at 0x20 or 0x24 per fire. Redirect to 0x80 during HALT → RUN with pc_o=0x80.
- Wrap and reset: pc_o=0xFFFFFFFC, fire → 0x00000000. Assert rst while pending=1 → pending cleared and pc_o=RESET_VEC.

Source files
------------

// File: rtl/pc_gen.sv
// pc_gen: fetch-stage program-counter generator.
// Drives the instruction-memory address (pc_o) and chip enable (ce_o), with
// prioritised redirects, a pending-redirect latch that survives stalls,
// target alignment checking and a halt mode. All outputs come from registers.
module pc_gen #(
  parameter int unsigned ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0,
  parameter int unsigned STEP       = 4,
  parameter int unsigned ALIGN_BITS = 2,
  parameter int unsigned NUM_REDIR  = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        stall_i,
  input  logic                        fetch_ready_i,
  input  logic                        halt_i,
  input  logic [NUM_REDIR-1:0]        redir_valid_i,
  input  logic [NUM_REDIR*ADDR_W-1:0] redir_target_i,
  output logic [ADDR_W-1:0]           pc_o,
  output logic                        ce_o,
  output logic                        misalign_o,
  output logic                        redir_pending_o
);

  typedef enum logic [1:0] {
    RST_S = 2'd0,
    RUN   = 2'd1,
    HALT  = 2'd2
  } state_t;

  // Low ALIGN_BITS cleared; ANDing a target with this forces alignment.
  localparam logic [ADDR_W-1:0] ALIGN_MASK = {ADDR_W{1'b1}} << ALIGN_BITS;
  localparam logic [ADDR_W-1:0] STEP_VAL   = ADDR_W'(STEP);

  state_t              state_reg, state_next;
  logic [ADDR_W-1:0]   pc_reg, pc_next;
  logic                ce_reg, ce_next;
  logic [ADDR_W-1:0]   pend_reg, pend_next;
  logic                pend_valid_reg, pend_valid_next;
  logic                misalign_reg, misalign_next;

  logic [ADDR_W-1:0]   target_arr [NUM_REDIR];
  logic                win_valid;
  logic [ADDR_W-1:0]   win_target;
  logic [ADDR_W-1:0]   win_aligned;
  logic                win_misaligned;
  logic                fire;

  // Unpack the flat target bus into one word per redirect source.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REDIR; gi++) begin : g_unpack
      assign target_arr[gi] = redir_target_i[gi*ADDR_W +: ADDR_W];
    end
  endgenerate

  // Priority select: scanning high to low leaves the lowest valid index last.
  always_comb begin
    win_valid  = |redir_valid_i;
    win_target = '0;
    for (int k = NUM_REDIR - 1; k >= 0; k--) begin
      if (redir_valid_i[k]) begin
        win_target = target_arr[k];
      end
    end
  end

  assign win_aligned    = win_target & ALIGN_MASK;
  assign win_misaligned = win_valid && ((win_target & ~ALIGN_MASK) != '0);

  // A fetch is accepted only while running with memory ready and no stall.
  assign fire = (state_reg == RUN) && ce_reg && fetch_ready_i && !stall_i;

  // State and datapath registers; rst discards everything including pending.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= RST_S;
      pc_reg         <= RESET_VEC;
      ce_reg         <= 1'b0;
      pend_reg       <= '0;
      pend_valid_reg <= 1'b0;
      misalign_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      pc_reg         <= pc_next;
      ce_reg         <= ce_next;
      pend_reg       <= pend_next;
      pend_valid_reg <= pend_valid_next;
      misalign_reg   <= misalign_next;
    end
  end

  // Next-state and next-PC selection.
  always_comb begin
    state_next      = state_reg;
    pc_next         = pc_reg;
    pend_next       = pend_reg;
    pend_valid_next = pend_valid_reg;
    misalign_next   = 1'b0;

    unique case (state_reg)
      RST_S: begin
        // Redirects are ignored here; the first fetch is RESET_VEC.
        state_next = RUN;
      end

      RUN: begin
        misalign_next = win_misaligned;
        if (fire) begin
          if (win_valid) begin
            pc_next = win_aligned;
          end else if (pend_valid_reg) begin
            pc_next = pend_reg;
          end else begin
            pc_next = pc_reg + STEP_VAL;
          end
          pend_valid_next = 1'b0;
        end else if (win_valid) begin
          // Newest redirect is the youngest correct path: overwrite.
          pend_next       = win_aligned;
          pend_valid_next = 1'b1;
        end
        if (halt_i) begin
          state_next = HALT;
        end
      end

      HALT: begin
        if (win_valid) begin
          // A redirect restarts fetch at its target and beats halt_i.
          misalign_next   = win_misaligned;
          state_next      = RUN;
          pc_next         = win_aligned;
          pend_valid_next = 1'b0;
        end else if (!halt_i) begin
          // Pending, if any, is kept for the next fire.
          state_next = RUN;
        end
      end

      default: begin
        state_next = RST_S;
      end
    endcase

    ce_next = (state_next == RUN);
  end

  assign pc_o            = pc_reg;
  assign ce_o            = ce_reg;
  assign misalign_o      = misalign_reg;
  assign redir_pending_o = pend_valid_reg;

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed test-plan sequences with literal
// expectations, followed by randomized traffic checked every cycle against a
// behavioural model of the fetch PC.
module tb_pc_gen;

  localparam int unsigned ADDR_W = 32;
  localparam logic [31:0] RVEC   = 32'h100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall_i = 1'b0;
  logic        fetch_ready_i = 1'b1;
  logic        halt_i = 1'b0;
  logic [1:0]  redir_valid_i = 2'b00;
  logic [63:0] redir_target_i = '0;
  logic [31:0] pc_o;
  logic        ce_o;
  logic        misalign_o;
  logic        redir_pending_o;

  int checks = 0;
  int failures = 0;
  bit check_en = 1'b0;

  always #5 clk = ~clk;

  pc_gen #(
    .ADDR_W(ADDR_W), .RESET_VEC(RVEC), .STEP(4), .ALIGN_BITS(2), .NUM_REDIR(2)
  ) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .fetch_ready_i(fetch_ready_i),
    .halt_i(halt_i), .redir_valid_i(redir_valid_i), .redir_target_i(redir_target_i),
    .pc_o(pc_o), .ce_o(ce_o), .misalign_o(misalign_o), .redir_pending_o(redir_pending_o)
  );

  // ---------------- behavioural model ----------------
  // mode: 0 = reset, 1 = running, 2 = halted
  int          m_mode = 0;
  logic [31:0] m_pc = RVEC;
  logic        m_ce = 1'b0;
  logic        m_mis = 1'b0;
  logic        m_pv = 1'b0;
  logic [31:0] m_pt = '0;

  always @(posedge clk) begin
    int          mode;
    logic [31:0] pc, pt, raw, al;
    logic        pv, mis, has, go;
    mode = m_mode; pc = m_pc; pv = m_pv; pt = m_pt; mis = 1'b0;
    has = (redir_valid_i != 2'b00);
    raw = redir_valid_i[0] ? redir_target_i[31:0] : redir_target_i[63:32];
    al  = {raw[31:2], 2'b00};
    if (rst) begin
      mode = 0; pc = RVEC; pv = 1'b0; pt = '0;
    end else if (m_mode == 0) begin
      mode = 1;
    end else if (m_mode == 1) begin
      go  = fetch_ready_i && !stall_i;
      mis = has && (raw[1:0] != 2'b00);
      if (go) begin
        if (has) pc = al;
        else if (pv) pc = pt;
        else pc = pc + 32'd4;
        pv = 1'b0;
      end else if (has) begin
        pt = al; pv = 1'b1;
      end
      if (halt_i) mode = 2;
    end else begin
      if (has) begin
        mis = (raw[1:0] != 2'b00);
        mode = 1; pc = al; pv = 1'b0;
      end else if (!halt_i) begin
        mode = 1;
      end
    end
    m_mode <= mode;
    m_pc   <= pc;
    m_ce   <= (mode == 1);
    m_mis  <= mis;
    m_pv   <= pv;
    m_pt   <= pt;
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (check_en) begin
      checks += 4;
      if (pc_o !== m_pc) begin
        failures++;
        $display("FAIL model_pc t=%0t got=%h exp=%h", $time, pc_o, m_pc);
      end
      if (ce_o !== m_ce) begin
        failures++;
        $display("FAIL model_ce t=%0t got=%b exp=%b", $time, ce_o, m_ce);
      end
      if (misalign_o !== m_mis) begin
        failures++;
        $display("FAIL model_misalign t=%0t got=%b exp=%b", $time, misalign_o, m_mis);
      end
      if (redir_pending_o !== m_pv) begin
        failures++;
        $display("FAIL model_pending t=%0t got=%b exp=%b", $time, redir_pending_o, m_pv);
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pin(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end else begin
      $display("ok   %s = %h", name, got);
    end
  endtask

  task automatic redir(input logic [1:0] v, input logic [31:0] t0, input logic [31:0] t1);
    redir_valid_i  = v;
    redir_target_i = {t1, t0};
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Reset held for two edges.
    tick();
    check_en = 1'b1;
    tick();
    pin("rst_pc", pc_o, 32'h100);
    pin("rst_ce", {31'b0, ce_o}, 32'h0);
    pin("rst_pend", {31'b0, redir_pending_o}, 32'h0);

    // Release: first edge only raises ce_o, then sequential fetch.
    rst = 1'b0;
    tick();
    pin("rel_pc0", pc_o, 32'h100);
    pin("rel_ce", {31'b0, ce_o}, 32'h1);
    tick();
    pin("rel_pc1", pc_o, 32'h104);
    tick();
    pin("rel_pc2", pc_o, 32'h108);

    // Two simultaneous redirects: source 0 wins.
    redir(2'b11, 32'h200, 32'h300);
    tick();
    pin("prio_pc", pc_o, 32'h200);
    redir(2'b00, 0, 0);
    tick();
    pin("prio_step", pc_o, 32'h204);

    // Redirect latched during a three-cycle stall.
    stall_i = 1'b1;
    redir(2'b10, 0, 32'h400);
    tick();
    pin("pend_set", {31'b0, redir_pending_o}, 32'h1);
    pin("pend_hold", pc_o, 32'h204);
    redir(2'b00, 0, 0);
    tick();
    tick();
    stall_i = 1'b0;
    tick();
    pin("pend_apply", pc_o, 32'h400);
    pin("pend_clr", {31'b0, redir_pending_o}, 32'h0);

    // Second redirect during a stall overwrites the first.
    stall_i = 1'b1;
    redir(2'b10, 0, 32'h400);
    tick();
    redir(2'b01, 32'h500, 0);
    tick();
    redir(2'b00, 0, 0);
    tick();
    stall_i = 1'b0;
    tick();
    pin("pend_newest", pc_o, 32'h500);

    // Misaligned target is aligned and flagged for exactly one cycle.
    redir(2'b01, 32'h1003, 0);
    tick();
    pin("mis_pc", pc_o, 32'h1000);
    pin("mis_hi", {31'b0, misalign_o}, 32'h1);
    redir(2'b00, 0, 0);
    tick();
    pin("mis_lo", {31'b0, misalign_o}, 32'h0);

    // Halt at 0x20 with no fetch accepted, then resume.
    redir(2'b01, 32'h20, 0);
    tick();
    redir(2'b00, 0, 0);
    fetch_ready_i = 1'b0;
    halt_i = 1'b1;
    tick();
    pin("halt_ce", {31'b0, ce_o}, 32'h0);
    pin("halt_pc", pc_o, 32'h20);
    halt_i = 1'b0;
    fetch_ready_i = 1'b1;
    tick();
    pin("resume_ce", {31'b0, ce_o}, 32'h1);
    pin("resume_pc", pc_o, 32'h20);
    tick();
    pin("resume_step", pc_o, 32'h24);
    // Halt coinciding with fire still advances; redirect leaves HALT.
    halt_i = 1'b1;
    tick();
    pin("halt_fire_pc", pc_o, 32'h28);
    redir(2'b10, 0, 32'h80);
    tick();
    pin("halt_redir_pc", pc_o, 32'h80);
    pin("halt_redir_ce", {31'b0, ce_o}, 32'h1);
    halt_i = 1'b0;
    redir(2'b00, 0, 0);
    tick();

    // Wrap-around.
    redir(2'b01, 32'hFFFF_FFFC, 0);
    tick();
    redir(2'b00, 0, 0);
    tick();
    pin("wrap_pc", pc_o, 32'h0);

    // Reset discards a pending redirect.
    stall_i = 1'b1;
    redir(2'b01, 32'h600, 0);
    tick();
    pin("rst_pend_pre", {31'b0, redir_pending_o}, 32'h1);
    redir(2'b00, 0, 0);
    rst = 1'b1;
    tick();
    pin("rst_pend_clr", {31'b0, redir_pending_o}, 32'h0);
    pin("rst_pend_pc", pc_o, 32'h100);
    rst = 1'b0;
    stall_i = 1'b0;
    tick();

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      logic [31:0] t0, t1;
      t0 = $urandom;
      t1 = $urandom;
      if ($urandom_range(0, 3) != 0) t0[1:0] = 2'b00;
      if ($urandom_range(0, 3) != 0) t1[1:0] = 2'b00;
      rst           = ($urandom_range(0, 99) == 0);
      stall_i       = ($urandom_range(0, 3) == 0);
      fetch_ready_i = ($urandom_range(0, 4) != 0);
      halt_i        = ($urandom_range(0, 9) == 0);
      redir_valid_i = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      redir_target_i = {t1, t0};
      tick();
    end

    rst = 1'b0;
    redir(2'b00, 0, 0);
    tick();
    check_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
